// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the ThinPad 5-stage core: load-use stalls,
// branch flushes, shared-IRAM structural stalls and registered EX forwarding selects.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_use_st,
  input  logic [3:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [3:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic        ex_branch_taken,
  input  logic        mem_iram_access,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  forwarding_a,
  output logic [1:0]  forwarding_b,
  output logic [1:0]  forward,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_IRAM_STALL = 2'b10;
  localparam logic [1:0] ST_FLUSH      = 2'b11;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  logic        w_load_use;
  logic [1:0]  w_next_state;
  logic [1:0]  w_sel_a;
  logic [1:0]  w_sel_b;
  logic [1:0]  w_sel_s;
  logic [1:0]  r_state;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [1:0]  r_fwd_s;
  logic [15:0] r_stall_cnt;

  // A load in EX cannot forward its ALU result, so only non-load EX writers qualify.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src,
    input logic       use_f,
    input logic [3:0] f_ex_rd,
    input logic       f_ex_regwrite,
    input logic       f_ex_memread,
    input logic [3:0] f_mem_rd,
    input logic       f_mem_regwrite
  );
    logic [1:0] sel;
    if (!use_f) begin
      sel = FWD_NONE;
    end else if (f_ex_regwrite && !f_ex_memread && (f_ex_rd == src)) begin
      sel = FWD_MEM;
    end else if (f_mem_regwrite && (f_mem_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  always_comb begin
    w_load_use = ex_memread && ex_regwrite &&
                 (((ex_rd == id_rs) && id_use_rs) ||
                  ((ex_rd == id_rt) && (id_use_rt || id_use_st)));
  end

  always_comb begin
    w_sel_a = fwd_sel(id_rs, id_use_rs, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite);
    w_sel_b = fwd_sel(id_rt, id_use_rt, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite);
    w_sel_s = fwd_sel(id_rt, id_use_st, ex_rd, ex_regwrite, ex_memread, mem_rd, mem_regwrite);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A taken branch squashes the ID instruction, so it outranks any load-use match.
  always_comb begin
    if (ex_branch_taken) begin
      w_next_state = ST_FLUSH;
    end else if (w_load_use) begin
      w_next_state = ST_LOAD_STALL;
    end else if (mem_iram_access) begin
      w_next_state = ST_IRAM_STALL;
    end else begin
      w_next_state = ST_RUN;
    end
  end

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (w_next_state)
      ST_FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      ST_LOAD_STALL: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      ST_IRAM_STALL: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
      end
      default: begin
        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
      end
    endcase
  end

  // A bubble entering EX must never forward, so flush clears the selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_a <= FWD_NONE;
      r_fwd_b <= FWD_NONE;
      r_fwd_s <= FWD_NONE;
    end else if (idex_flush) begin
      r_fwd_a <= FWD_NONE;
      r_fwd_b <= FWD_NONE;
      r_fwd_s <= FWD_NONE;
    end else if (ifid_stall) begin
      r_fwd_a <= r_fwd_a;
      r_fwd_b <= r_fwd_b;
      r_fwd_s <= r_fwd_s;
    end else begin
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
      r_fwd_s <= w_sel_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (pc_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign forwarding_a = r_fwd_a;
  assign forwarding_b = r_fwd_b;
  assign forward      = r_fwd_s;
  assign state        = r_state;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a reference model pushes expected
// registered results per cycle, popped and compared after the clock edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_use_rs, id_use_rt, id_use_st;
  logic        ex_regwrite, ex_memread, mem_regwrite;
  logic        ex_branch_taken, mem_iram_access;
  logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
  logic [1:0]  forwarding_a, forwarding_b, forward, state;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [1:0]  fs;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // Model of the registered state as of the last clock edge.
  logic [1:0]  m_fa = 2'd0, m_fb = 2'd0, m_fs = 2'd0;
  logic [15:0] m_cnt = 16'd0;
  logic [15:0] c0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_st(id_use_st),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .ex_branch_taken(ex_branch_taken), .mem_iram_access(mem_iram_access),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .forwarding_a(forwarding_a), .forwarding_b(forwarding_b), .forward(forward),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] rs, input logic [3:0] rt,
                       input logic urs, input logic urt, input logic ust,
                       input logic [3:0] exrd, input logic exw, input logic exm,
                       input logic [3:0] memrd, input logic memw,
                       input logic br, input logic iram);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_use_st = ust;
    ex_rd = exrd; ex_regwrite = exw; ex_memread = exm;
    mem_rd = memrd; mem_regwrite = memw;
    ex_branch_taken = br; mem_iram_access = iram;
  endtask

  function automatic logic [1:0] m_sel(input logic [3:0] r, input logic u);
    if (!u) return 2'b00;
    if (ex_regwrite && !ex_memread && ex_rd == r) return 2'b01;
    if (mem_regwrite && mem_rd == r) return 2'b10;
    return 2'b00;
  endfunction

  // One clock: check combinational controls, push expected registered values,
  // then pop and compare after the edge.
  task automatic step(input bit chk);
    logic lu;
    logic e_pc, e_ifs, e_iff, e_idf;
    exp_t e, got;
    #1;
    lu = ex_memread && ex_regwrite &&
         ((id_use_rs && ex_rd == id_rs) || ((id_use_rt || id_use_st) && ex_rd == id_rt));
    if (ex_branch_taken) begin
      {e_pc, e_ifs, e_iff, e_idf} = 4'b0011; e.st = 2'b11;
    end else if (lu) begin
      {e_pc, e_ifs, e_iff, e_idf} = 4'b1101; e.st = 2'b01;
    end else if (mem_iram_access) begin
      {e_pc, e_ifs, e_iff, e_idf} = 4'b1010; e.st = 2'b10;
    end else begin
      {e_pc, e_ifs, e_iff, e_idf} = 4'b0000; e.st = 2'b00;
    end
    if (chk) begin
      check("pc_stall", pc_stall, e_pc);
      check("ifid_stall", ifid_stall, e_ifs);
      check("ifid_flush", ifid_flush, e_iff);
      check("idex_flush", idex_flush, e_idf);
    end
    if (e_idf) begin
      e.fa = 2'b00; e.fb = 2'b00; e.fs = 2'b00;
    end else if (e_ifs) begin
      e.fa = m_fa; e.fb = m_fb; e.fs = m_fs;
    end else begin
      e.fa = m_sel(id_rs, id_use_rs);
      e.fb = m_sel(id_rt, id_use_rt);
      e.fs = m_sel(id_rt, id_use_st);
    end
    e.cnt = (e_pc && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    if (chk) begin
      check("forwarding_a", forwarding_a, got.fa);
      check("forwarding_b", forwarding_b, got.fb);
      check("forward", forward, got.fs);
      check("state", state, got.st);
      check("stall_cnt", stall_cnt, got.cnt);
    end
    m_fa = got.fa; m_fb = got.fb; m_fs = got.fs; m_cnt = got.cnt;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_state", state, 2'b00);
    check("rst_fa", forwarding_a, 2'b00);
    check("rst_fb", forwarding_b, 2'b00);
    check("rst_fs", forward, 2'b00);
    check("rst_cnt", stall_cnt, 16'd0);
    // Controls stay combinational while reset is held.
    drive(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_comb_pc_stall", pc_stall, 1'b1);
    check("rst_comb_idex_flush", idex_flush, 1'b1);
    @(posedge clk); #1;
    check("rst_hold_state", state, 2'b00);
    check("rst_hold_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);

    // Load-use on rs, then the consumer forwards from WB.
    drive(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    check("lu_state", state, 2'b01);
    drive(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1 check("lu_no_second_stall", pc_stall, 1'b0);
    step(1'b1);
    check("lu_fwd_wb", forwarding_a, 2'b10);

    // Both producers match: EX wins.
    drive(4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    check("dbl_fb", forwarding_b, 2'b01);

    // Branch with simultaneous load-use and a matching MEM producer.
    drive(4'd5, 4'd2, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
    step(1'b1);
    check("br_state", state, 2'b11);
    check("br_fa", forwarding_a, 2'b00);
    check("br_fb", forwarding_b, 2'b00);

    // Store-data operand forwarding, then all use flags clear.
    drive(4'd0, 4'd6, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    check("st_fwd", forward, 2'b01);
    drive(4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1);

    // Load-use through the store operand outranks an IRAM access.
    drive(4'd0, 4'd4, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1);
    check("lu_st_state", state, 2'b01);

    // Shared IRAM for 3 cycles, then again with a branch in the middle cycle.
    c0 = m_cnt;
    drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1);
    check("iram_cnt3", stall_cnt, c0 + 16'd3);
    check("iram_state", state, 2'b10);
    c0 = m_cnt;
    step(1'b1);
    ex_branch_taken = 1'b1;
    step(1'b1);
    check("iram_br_state", state, 2'b11);
    ex_branch_taken = 1'b0;
    step(1'b1);
    check("iram_br_cnt", stall_cnt, c0 + 16'd2);

    // IRAM stall does not flush ID/EX, so forwarding still registers.
    drive(4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1);
    step(1'b1);
    check("iram_fa", forwarding_a, 2'b10);

    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            4'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) == 0));
      step(1'b1);
    end

    // Reset between edges during a load-use stall.
    drive(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    check("pre_rst_state", state, 2'b01);
    rst = 1'b1;
    #1;
    check("mid_rst_state", state, 2'b00);
    check("mid_rst_fa", forwarding_a, 2'b00);
    check("mid_rst_fb", forwarding_b, 2'b00);
    check("mid_rst_fs", forward, 2'b00);
    check("mid_rst_cnt", stall_cnt, 16'd0);
    #1 rst = 1'b0;
    m_fa = 2'd0; m_fb = 2'd0; m_fs = 2'd0; m_cnt = 16'd0;
    drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1);
    check("post_rst_cnt", stall_cnt, 16'd0);

    // Saturation of the stall counter.
    drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    repeat (66000) step(1'b0);
    check("sat_cnt", stall_cnt, 16'hFFFF);
    step(1'b1);
    check("sat_hold", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high. Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_rs  in  4  ID-stage source register 1 (ThinPad index 0-7 GPR, 8 SP, 9 IH, 10 T, 11 RA)
- id_rt  in  4  ID-stage source register 2 / store-data register
- id_use_rs, id_use_rt, id_use_st  in  1 each  ID instruction reads id_rs / id_rt as ALU B / id_rt as store data
- ex_rd  in  4  EX-stage destination; ex_regwrite, ex_memread  in  1 each
- mem_rd  in  4  MEM-stage destination; mem_regwrite  in  1
- ex_branch_taken  in  1  EX resolved NewPC differs from sequential PC (jump, or taken B/BEQZ/BNEZ)
- mem_iram_access  in  1  MEM stage uses the shared instruction RAM this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_flush  out  1  load bubble (NOP) into IF/ID
- idex_flush  out  1  load bubble into ID/EX
- forwarding_a, forwarding_b, forward  out  2 each  registered selects to the EX stage: 00 register file / immediate, 01 ALU result of the MEM stage, 10 write-back data, 11 never driven
- state  out  2  FSM state: 00 RUN, 01 LOAD_STALL, 10 IRAM_STALL, 11 FLUSH
- stall_cnt  out  16  saturating count of cycles with pc_stall=1

Function
REQ-002 Hazard detection SHALL be combinational from the current inputs. Selects, state and counter SHALL be registered.
REQ-003 Load-use condition: ex_memread=1, ex_regwrite=1, and ex_rd matches id_rs (with id_use_rs=1) or id_rt (with id_use_rt=1 or id_use_st=1).
REQ-004 Priority, highest first:
- ex_branch_taken: ifid_flush=1, idex_flush=1, pc_stall=0, ifid_stall=0. A simultaneous load-use is ignored because the ID instruction is squashed.
- Load-use: pc_stall=1, ifid_stall=1, idex_flush=1, ifid_flush=0. This holds regardless of mem_iram_access.
- mem_iram_access: pc_stall=1, ifid_flush=1, ifid_stall=0, idex_flush=0.
- Otherwise all four controls are 0.
REQ-005 Forwarding selects SHALL be computed for the ID instruction and registered at each rising edge, so they are valid while that instruction is in EX.
REQ-006 Per operand (id_rs -> forwarding_a, id_rt with id_use_rt -> forwarding_b, id_rt with id_use_st -> forward):
- 01 if ex_regwrite=1, ex_memread=0 and ex_rd matches.
- Otherwise 10 if mem_regwrite=1 and mem_rd matches.
- Otherwise 00.
- If the operand's use flag is 0, the select is 00.
REQ-007 The newer producer (EX) SHALL win over the older (MEM) when both match.
REQ-008 In any cycle where idex_flush=1, all three selects SHALL be registered as 00, so the bubble never forwards.
REQ-009 If ifid_stall=1 and idex_flush=0 (not reachable per REQ-004), the selects SHALL hold their values.
REQ-010 The FSM SHALL register the winning condition each cycle: FLUSH, LOAD_STALL, IRAM_STALL, or RUN if none. There are no multi-cycle sequences; each stall or flush is re-evaluated every cycle.
REQ-011 stall_cnt SHALL increment on every rising edge where pc_stall=1 and SHALL saturate at 16'hFFFF with no wrap.
REQ-012 After a 1-cycle load-use stall, the consumer's selects SHALL resolve to 10 (load now in WB), with no second stall.

Reset
REQ-013 While rst=1, and asynchronously on its assertion: forwarding_a/b, forward = 00; state = RUN; stall_cnt = 0.
REQ-014 The combinational controls follow the inputs during reset. Assertion mid-stall SHALL drop state to RUN immediately.
REQ-015 The first rising edge after rst deasserts SHALL resume normal evaluation with no residual stall.

Verification
REQ-016 Load-use: ex_memread=1, ex_regwrite=1, ex_rd=3, id_rs=3, id_use_rs=1 -> pc_stall=1, ifid_stall=1, idex_flush=1 for 1 cycle, state=01. Next cycle mem_rd=3, mem_regwrite=1 -> forwarding_a=10 registered after that edge.
REQ-017 Double producer: ex_rd=2 (ALU, regwrite=1), mem_rd=2 (regwrite=1), id_rt=2, id_use_rt=1 -> forwarding_b=01 after the edge, no stall.
REQ-018 Branch plus load-use in the same cycle: ex_branch_taken=1 with a load-use match -> ifid_flush=1, idex_flush=1, pc_stall=0, state=11, all selects 00.
REQ-019 Shared RAM: mem_iram_access=1 for 3 cycles, no other hazard -> pc_stall=1, ifid_flush=1 each cycle, state=10, stall_cnt +3. With ex_branch_taken=1 in the 2nd cycle, that cycle gives pc_stall=0 and both flushes=1.
REQ-020 Counter saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF.
REQ-021 Reset mid-stall: assert rst between edges during LOAD_STALL -> state=00, selects=00, stall_cnt=0 before the next edge.
